// File: rtl/vc_fifo_pkg.sv
// vc_fifo shared constants and helpers.
// Optional error reporting is enabled with VC_FIFO_ERR_EN.
package vc_fifo_pkg;
  localparam int DEPTH = 8;
  localparam int COUNT_W = $clog2(DEPTH) + 1;

  function automatic int cnt_off(input int v, input int w);
    return v * w;
  endfunction
endpackage

// File: rtl/vc_fifo_ctrl.sv
// Per-channel pointer and occupancy tracking for vc_fifo.
// Defining VC_FIFO_ERR_EN does not change this module.
module vc_fifo_ctrl
  import vc_fifo_pkg::*;
#(
  parameter int QB = $clog2(DEPTH),
  parameter int Q_IN_BUFFERS = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_hit,
  input  logic          rd_hit,
  input  logic          bypass,
  output logic [QB-1:0] front,
  output logic [QB-1:0] rear,
  output logic [QB:0]   count,
  output logic          full,
  output logic          empty
);
  localparam int D = 1 << QB;
  localparam logic [QB:0] DL = (QB+1)'(D);
  localparam logic [QB:0] FL = (QB+1)'(D - Q_IN_BUFFERS);

  logic wr_ok;
  logic rd_ok;

  // A consumed bypass never touches the queue
  assign wr_ok = wr_hit & ~bypass & (count < DL);
  assign rd_ok = rd_hit & (count != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      front <= '0;
      rear  <= '0;
      count <= '0;
    end else begin
      if (wr_ok) rear <= rear + 1'b1;
      if (rd_ok) front <= front + 1'b1;
      if (wr_ok && !rd_ok) count <= count + 1'b1;
      else if (rd_ok && !wr_ok) count <= count - 1'b1;
    end
  end

  assign full  = (count >= FL);
  assign empty = (count == '0);
endmodule

// File: rtl/vc_fifo.sv
// Multi-channel FIFO: NUM_VC circular queues in one array.
// Define VC_FIFO_ERR_EN to add the sticky err port and messages.
module vc_fifo
  import vc_fifo_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int Q_DEPTH_BITS = COUNT_W - 1,
  parameter int NUM_VC       = 4,
  parameter int VC_BITS      = 2,
  parameter int Q_IN_BUFFERS = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  wrtEn,
  input  logic [VC_BITS-1:0]    wr_vc,
  input  logic                  rdEn,
  input  logic                  peek,
  input  logic [VC_BITS-1:0]    rd_vc,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  valid,
  output logic [NUM_VC-1:0]     full,
  output logic [NUM_VC-1:0]     empty,
  output logic [NUM_VC*(Q_DEPTH_BITS+1)-1:0] count
`ifdef VC_FIFO_ERR_EN
  ,
  output logic [2*NUM_VC-1:0]   err
`endif
);
  localparam int CW = Q_DEPTH_BITS + 1;
  localparam int D  = 1 << Q_DEPTH_BITS;
  localparam logic [CW-1:0] DL = CW'(D);

  logic [Q_DEPTH_BITS-1:0] front [NUM_VC];
  logic [Q_DEPTH_BITS-1:0] rear  [NUM_VC];
  logic [CW-1:0]           cnt   [NUM_VC];
  logic [DATA_WIDTH-1:0]   mem   [NUM_VC*D];

  logic byp;
  logic byp_rd;
  logic wr_ok;
  logic hd_ok;

  assign byp = reset & wrtEn & (rdEn | peek)
             & (wr_vc == rd_vc) & empty[rd_vc];
  assign byp_rd = byp & rdEn;
  assign wr_ok = reset & wrtEn & (cnt[wr_vc] != DL) & ~byp_rd;
  assign hd_ok = reset & (rdEn | peek) & ~empty[rd_vc];
  assign valid = byp | hd_ok;

  always_comb begin
    read_data = '0;
    if (byp) read_data = write_data;
    else if (hd_ok) read_data = mem[{rd_vc, front[rd_vc]}];
  end

  // Storage is deliberately left out of reset
  always_ff @(posedge clk) begin
    if (wr_ok) mem[{wr_vc, rear[wr_vc]}] <= write_data;
  end

  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    vc_fifo_ctrl #(
      .QB(Q_DEPTH_BITS),
      .Q_IN_BUFFERS(Q_IN_BUFFERS)
    ) u_ctrl (
      .clk(clk),
      .reset(reset),
      .wr_hit(wrtEn & (wr_vc == VC_BITS'(v))),
      .rd_hit(rdEn & (rd_vc == VC_BITS'(v))),
      .bypass(byp_rd & (wr_vc == VC_BITS'(v))),
      .front(front[v]),
      .rear(rear[v]),
      .count(cnt[v]),
      .full(full[v]),
      .empty(empty[v])
    );
    assign count[cnt_off(v, CW) +: CW] = cnt[v];
  end

`ifdef VC_FIFO_ERR_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err <= '0;
    end else begin
      if (wrtEn && cnt[wr_vc] == DL) begin
        err[wr_vc] <= 1'b1;
`ifndef SYNTHESIS
        $display("vc_fifo: overflow on vc %0d", wr_vc);
`endif
      end
      if (rdEn && empty[rd_vc] && !byp) begin
        err[NUM_VC + int'(rd_vc)] <= 1'b1;
`ifndef SYNTHESIS
        $display("vc_fifo: underflow on vc %0d", rd_vc);
`endif
      end
    end
  end
`endif
endmodule

// File: tb/tb_vc_fifo.sv
// Scoreboard bench for vc_fifo.
// Build with VC_FIFO_ERR_EN to also check the err port.
module tb_vc_fifo;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] write_data;
  logic        wrtEn;
  logic [1:0]  wr_vc;
  logic        rdEn;
  logic        peek;
  logic [1:0]  rd_vc;
  logic [31:0] read_data;
  logic        valid;
  logic [3:0]  full;
  logic [3:0]  empty;
  logic [15:0] count;
`ifdef VC_FIFO_ERR_EN
  logic [7:0]  err;
`endif

  vc_fifo dut (
    .clk(clk),
    .reset(reset),
    .write_data(write_data),
    .wrtEn(wrtEn),
    .wr_vc(wr_vc),
    .rdEn(rdEn),
    .peek(peek),
    .rd_vc(rd_vc),
    .read_data(read_data),
    .valid(valid),
    .full(full),
    .empty(empty),
    .count(count)
`ifdef VC_FIFO_ERR_EN
    ,
    .err(err)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [31:0] mq [4][$];
  logic [7:0]  merr = '0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    wrtEn = 1'b0;
    rdEn = 1'b0;
    peek = 1'b0;
    wr_vc = '0;
    rd_vc = '0;
    write_data = '0;
  endtask

  task automatic op(input bit we, input int wv, input logic [31:0] wd,
                    input bit re, input bit pk, input int rv);
    bit byp;
    bit wacc;
    bit racc;
    @(negedge clk);
    wrtEn = we;
    wr_vc = wv[1:0];
    write_data = wd;
    rdEn = re;
    peek = pk;
    rd_vc = rv[1:0];
    #1;
    byp = we && (re || pk) && wv == rv && mq[rv].size() == 0;
    if (re || pk) begin
      if (byp) begin
        check("byp_valid", 64'(valid), 64'd1);
        check("byp_data", 64'(read_data), 64'(wd));
      end else if (mq[rv].size() > 0) begin
        check("rd_valid", 64'(valid), 64'd1);
        check("rd_data", 64'(read_data), 64'(mq[rv][0]));
      end else begin
        check("rd_valid0", 64'(valid), 64'd0);
        check("rd_data0", 64'(read_data), 64'd0);
      end
    end
    if (we && mq[wv].size() == 8) merr[wv] = 1'b1;
    if (re && !byp && mq[rv].size() == 0) merr[4 + rv] = 1'b1;
    wacc = we && mq[wv].size() < 8 && !(byp && re);
    racc = re && !byp && mq[rv].size() > 0;
    if (racc) void'(mq[rv].pop_front());
    if (wacc) mq[wv].push_back(wd);
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic status(input string tag);
    for (int v = 0; v < 4; v++) begin
      check({tag, "_cnt"}, 64'(count[v*4 +: 4]), 64'(mq[v].size()));
      check({tag, "_emp"}, 64'(empty[v]), 64'(mq[v].size() == 0));
      check({tag, "_full"}, 64'(full[v]), 64'(mq[v].size() >= 6));
    end
`ifdef VC_FIFO_ERR_EN
    check({tag, "_err"}, 64'(err), 64'(merr));
`endif
  endtask

  initial begin
    idle();
    reset = 1'b0;
    #1;
    rdEn = 1'b1;
    rd_vc = 2'd1;
    #1;
    check("rst_empty", 64'(empty), 64'hF);
    check("rst_full", 64'(full), 64'h0);
    check("rst_count", 64'(count), 64'h0);
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_data", 64'(read_data), 64'd0);
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 4; i++) op(1, 1, 32'hA0 + 32'(i), 0, 0, 0);
    check("vc1_cnt4", 64'(count[7:4]), 64'd4);
    check("vc1_emp", 64'(empty), 64'hD);
    status("fill1");
    for (int i = 0; i < 4; i++) op(0, 0, 0, 1, 0, 1);
    status("drain1");

    op(1, 2, 32'h55, 1, 0, 2);
    check("byp_cnt2", 64'(count[11:8]), 64'd0);
    status("byp");

    for (int i = 0; i < 8; i++) begin
      op(1, 0, 32'hC0 + 32'(i), 0, 0, 0);
      if (i == 4) check("full_lo", 64'(full[0]), 64'd0);
      if (i == 5) check("full_hi", 64'(full[0]), 64'd1);
    end
    op(1, 0, 32'hFF, 0, 0, 0);
    status("over");
    for (int i = 0; i < 8; i++) op(0, 0, 0, 1, 0, 0);
    op(0, 0, 0, 1, 0, 0);
    status("under");

    op(1, 0, 32'h10, 0, 0, 0);
    op(1, 3, 32'h30, 0, 0, 0);
    op(1, 0, 32'h11, 0, 0, 0);
    op(1, 3, 32'h31, 0, 0, 0);
    op(0, 0, 0, 1, 0, 3);
    op(0, 0, 0, 1, 0, 3);
    check("vc0_kept", 64'(count[3:0]), 64'd2);
    status("inter");

    op(0, 0, 0, 0, 1, 0);
    op(1, 3, 32'h77, 0, 1, 3);
    status("peek");
    op(0, 0, 0, 1, 0, 3);

    for (int i = 0; i < 3; i++) op(1, 1, $urandom, 0, 0, 0);
    for (int i = 0; i < 200; i++) begin
      op(1, 1, $urandom, 1, 0, 1);
      if (i % 50 == 0) check("wrap_cnt", 64'(count[7:4]), 64'd3);
    end
    status("wrap");

    for (int i = 0; i < 5; i++) op(1, 2, 32'hE0 + 32'(i), 0, 0, 0);
    status("pre_rst");
    @(negedge clk);
    rdEn = 1'b1;
    rd_vc = 2'd2;
    #2;
    reset = 1'b0;
    #1;
    check("mid_empty", 64'(empty), 64'hF);
    check("mid_valid", 64'(valid), 64'd0);
    check("mid_data", 64'(read_data), 64'd0);
    check("mid_count", 64'(count), 64'h0);
    for (int v = 0; v < 4; v++) mq[v].delete();
    merr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    idle();
    reset = 1'b1;
    op(0, 0, 0, 1, 0, 2);
    status("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vc_fifo.md
# vc_fifo

Multi-channel successor to the single-queue `fifo`. It holds NUM_VC independent circular queues in one storage array, behind a single write port and a single read port, each selected by a channel index. It keeps same-cycle write-to-read bypass on an empty queue and adds per-channel full/empty/count status. It sits at router input ports, where each virtual channel needs its own buffer and its own back-pressure.

## Interface
- DATA_WIDTH, 32, payload width
- Q_DEPTH_BITS, 3, log2 of per-channel depth; DEPTH = 1 << Q_DEPTH_BITS
- NUM_VC, 4, number of channels (≥ 2)
- VC_BITS, 2, channel index width; must equal clog2(NUM_VC)
- Q_IN_BUFFERS, 2, slack entries reserved for in-flight flits; per-channel `full` asserts at count ≥ DEPTH − Q_IN_BUFFERS
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-low (0 = reset)
- write_data  input  DATA_WIDTH  enqueue payload
- wrtEn  input  1  enqueue request
- wr_vc  input  VC_BITS  target channel of the write
- rdEn  input  1  dequeue request
- peek  input  1  look at head without dequeue
- rd_vc  input  VC_BITS  channel for rdEn/peek
- read_data  output  DATA_WIDTH  head of rd_vc, or bypassed write_data; 0 when valid=0
- valid  output  1  read_data is meaningful this cycle
- full  output  NUM_VC  per-channel threshold full
- empty  output  NUM_VC  per-channel count == 0
- count  output  NUM_VC*(Q_DEPTH_BITS+1)  per-channel occupancy, channel v at bits [v*(Q_DEPTH_BITS+1) +: Q_DEPTH_BITS+1]

## Operation
- Per channel: front/rear pointers of Q_DEPTH_BITS bits and a count of Q_DEPTH_BITS+1 bits.
- Storage address is {vc, ptr}, giving NUM_VC*DEPTH entries. Pointers wrap naturally from DEPTH−1 to 0.
- The write is accepted iff wrtEn and count[wr_vc] < DEPTH. A write to a channel at DEPTH entries is dropped: no state change.
- The read is accepted iff rdEn and count[rd_vc] > 0. A read of an empty channel (no bypass) is ignored: valid=0.
- Bypass: wrtEn & (rdEn|peek) & wr_vc==rd_vc & count==0.
  - read_data = write_data and valid = 1.
  - With rdEn, nothing is stored and count stays 0.
  - With peek only, the write is stored normally.
- Write and read accepted on the same channel with count > 0: both pointers advance and count is unchanged.
- Write and read on different channels: each channel updates independently.
- peek never moves pointers. rdEn has priority over peek when both are high.
- read_data = mem[{rd_vc, front[rd_vc]}] when not bypassing.
- full[v] and empty[v] are derived from the registered count only. There is no look-ahead term.

## Timing
- Read path is combinational: read_data and valid are valid in the same cycle as rdEn/peek. Dequeue takes effect at the next rising edge.
- A write is visible at the head from the cycle after the write edge. Write-to-read latency is 1 cycle, or 0 cycles via bypass.
- Status updates one edge after the causing operation.
- On reset assertion (async, immediate):
  - all pointers and counts go to 0
  - empty = all 1s, full = 0, count = 0, valid = 0, read_data = 0
  - storage is not reset
- While reset=0, all requests are ignored. Release is synchronous to clk. The first edge after release may accept a write.
- Reset mid-transfer discards all queued data on every channel.

## Configuration
- `VC_FIFO_ERR_EN`
  - Defined:
    - adds output `err` (2*NUM_VC bits): bit v = sticky overflow (write dropped on channel v), bit NUM_VC+v = sticky underflow (rdEn on empty channel v without bypass)
    - `err` is cleared only by reset
    - simulation `$display` messages for the same events
  - Undefined: no `err` port; illegal operations are silently ignored exactly as above.

## Structure
- Package `vc_fifo_pkg`:
  - localparams for DEPTH and COUNT_W = Q_DEPTH_BITS+1
  - helper function for the flat count slice offset
- Sub-module `vc_fifo_ctrl`, instantiated NUM_VC times via generate:
  - inputs: wr_hit, rd_hit, bypass
  - owns front, rear and count
  - produces full, empty and count
- The top level owns the storage array, address muxing and the read/bypass mux.

## Test plan
- Reset, then write 0xA0..0xA3 to vc 1 → count[1]=4, empty=4'b1101. Then rdEn vc 1 four times → read_data 0xA0, 0xA1, 0xA2, 0xA3 in order, then empty[1]=1.
- Empty vc 2, wrtEn+rdEn, wr_vc=rd_vc=2, data 0x55 → same cycle read_data=0x55 and valid=1; count[2] stays 0.
- Fill vc 0 with 8 entries (Q_IN_BUFFERS=2) → full[0] rises after the 6th write. A 9th write of 0xFF is dropped; subsequent reads return the original 8 values. With the macro defined, err[0]=1.
- Interleave vc 0 and vc 3 writes (0x10, 0x30, 0x11, 0x31) → reads of vc 3 return 0x30, 0x31 and vc 0 is untouched (count[0]=2).
- Fill vc 1 to 3 entries, issue simultaneous write/read 200 times → count[1] stays 3, pointers wrap, data stays FIFO-ordered.
- Assert reset=0 asynchronously mid-stream with 5 entries in vc 2 → empty=all 1s and valid=0 before the next edge. After release, rdEn vc 2 gives valid=0.
